fpdiv_arbiter: RTL and testbench
================================

Name: fpdiv_arbiter

Overview:
Shares a single fpdiv divider unit among NUM_REQ requesters using round-robin arbitration. Per operation it:
- accepts one operand pair,
- holds the operands stable on the divider inputs,
- issues a one-cycle start pulse on the divider's active-high RESET input,
- waits for DONE,
- returns the result, exception code and requester ID over a valid/ready response channel.

It sits between the request sources and the fpdiv instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of RSP_ID; must be >= clog2(NUM_REQ)
TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with FPDIV_TIMEOUT_EN)

Ports:
CLOCK  in  1  single clock; all state changes on posedge
RESET_N  in  1  asynchronous, active-low reset
REQ_VALID  in  NUM_REQ  per-requester request valid
REQ_READY  out  NUM_REQ  one-hot accept strobe
REQ_A  in  32*NUM_REQ  dividends, requester k at [32k+31:32k]
REQ_B  in  32*NUM_REQ  divisors, same packing
RSP_VALID  out  1  response valid
RSP_READY  in  1  response accepted
RSP_ID  out  ID_W  index of requester that owns the response
RSP_RESULT  out  32  quotient
RSP_EXCEPTION  out  2  exception code
DIV_A  out  32  to fpdiv InputA
DIV_B  out  32  to fpdiv InputB
DIV_START  out  1  to fpdiv RESET (start pulse)
DIV_RESULT  in  32  from fpdiv AbyB
DIV_DONE  in  1  from fpdiv DONE
DIV_EXCEPTION  in  2  from fpdiv EXCEPTION
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE, rr pointer=NUM_REQ-1.
  - All outputs 0, including DIV_A, DIV_B, RSP_* and TIMEOUT_ERR.
  - Reset mid-operation abandons the job; no response is produced.
  - The divider is not re-synchronised until the next ISSUE.
- IDLE:
  - If any REQ_VALID, grant the first valid index searching upward from (rr pointer+1) mod NUM_REQ.
  - REQ_READY[g]=1 combinationally in that cycle only; the accept is REQ_VALID[g]&REQ_READY[g].
  - On the edge: latch DIV_A/DIV_B from requester g, latch tag=g, set rr pointer=g, go to ISSUE.
  - No REQ_READY is asserted in any other state.
- ISSUE:
  - DIV_START=1 for exactly one cycle; DIV_A/DIV_B are already stable.
  - Go to GUARD.
- GUARD:
  - One cycle; DIV_DONE is ignored here because the divider clears DONE on the start edge.
  - Go to WAIT.
- WAIT:
  - On the first cycle with DIV_DONE=1, capture RSP_RESULT=DIV_RESULT, RSP_EXCEPTION=DIV_EXCEPTION and RSP_ID=tag.
  - Set RSP_VALID=1 and go to RESPOND.
- RESPOND:
  - RSP_* hold stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_READY=1: RSP_VALID->0 next cycle and go to IDLE.
  - A new grant happens no earlier than the cycle after return to IDLE (at most one job in flight).
- DIV_A/DIV_B hold their value from grant until the next grant; they are never changed during ISSUE, GUARD or WAIT.
- Minimum latency, accept edge to RSP_VALID: 3 cycles plus divider latency.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 other jobs.
- A requester deasserting REQ_VALID before it is granted loses nothing; its request is simply not taken.

Optional Feature:
Macro FPDIV_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with DIV_DONE still 0: RSP_RESULT=32'h7FC00000, RSP_EXCEPTION=2'b11, RSP_ID=tag, go to RESPOND.
  - Extra output TIMEOUT_ERR (1 bit) is set sticky on a timeout and cleared only by RESET_N.
- Undefined:
  - WAIT lasts indefinitely, with no counter and no TIMEOUT_ERR port.

Test Plan:
1. Single request, req 0, A=0x40C00000 (6.0), B=0x40000000 (2.0), real fpdiv attached -> exactly one DIV_START pulse; then RSP_VALID with RSP_RESULT=0x40400000, RSP_ID=0.
2. All 4 REQ_VALID held high, RSP_READY=1, model divider with 5-cycle latency -> grant order 0,1,2,3,0; DIV_A/DIV_B never change between START and DONE.
3. Back-pressure: RSP_READY=0 for 10 cycles after RSP_VALID -> RSP_* stable, no REQ_READY and no DIV_START; on release, next grant occurs in IDLE.
4. Model drives DIV_DONE=1 left over from the previous job through ISSUE/GUARD, then drops it and reasserts after 4 cycles -> response captured only on the reasserted DONE.
5. RESET_N low during WAIT -> all outputs 0 immediately (asynchronously), no response emitted, next request serviced normally.
6. With FPDIV_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never raises DONE -> after 16 WAIT cycles RSP_RESULT=0x7FC00000, RSP_EXCEPTION=2'b11, TIMEOUT_ERR=1 and staying high.

Source files
------------

// File: rtl/fpdiv_arbiter_if.sv
// Request, response and divider-side signal bundle for fpdiv_arbiter.
// master is the arbiter's view; slave is the view of the requesters, response sink and divider.
interface fpdiv_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    REQ_VALID;
   logic [NUM_REQ-1:0]    REQ_READY;
   logic [32*NUM_REQ-1:0] REQ_A;
   logic [32*NUM_REQ-1:0] REQ_B;
   logic                  RSP_VALID;
   logic                  RSP_READY;
   logic [ID_W-1:0]       RSP_ID;
   logic [31:0]           RSP_RESULT;
   logic [1:0]            RSP_EXCEPTION;
   logic [31:0]           DIV_A;
   logic [31:0]           DIV_B;
   logic                  DIV_START;
   logic [31:0]           DIV_RESULT;
   logic                  DIV_DONE;
   logic [1:0]            DIV_EXCEPTION;

   modport master (
      input  REQ_VALID, REQ_A, REQ_B, RSP_READY, DIV_RESULT, DIV_DONE, DIV_EXCEPTION,
      output REQ_READY, RSP_VALID, RSP_ID, RSP_RESULT, RSP_EXCEPTION, DIV_A, DIV_B, DIV_START
   );

   modport slave (
      output REQ_VALID, REQ_A, REQ_B, RSP_READY, DIV_RESULT, DIV_DONE, DIV_EXCEPTION,
      input  REQ_READY, RSP_VALID, RSP_ID, RSP_RESULT, RSP_EXCEPTION, DIV_A, DIV_B, DIV_START
   );
endinterface

// File: rtl/fpdiv_arbiter.sv
// Round-robin front end sharing one fpdiv unit among NUM_REQ requesters, one job in flight.
// Define FPDIV_TIMEOUT_EN to add a WAIT-state watchdog and the sticky TIMEOUT_ERR output.
module fpdiv_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            CLOCK,
   input  logic            RESET_N,
   fpdiv_arbiter_if.master bus,
   output logic            BUSY
`ifdef FPDIV_TIMEOUT_EN
   ,
   output logic            TIMEOUT_ERR
`endif
);

   // state   | meaning
   // IDLE    | no job; grant the next valid requester round-robin
   // ISSUE   | operands held on DIV_A/DIV_B, start pulse to the divider
   // GUARD   | one cycle for the divider to drop a stale DONE
   // WAIT    | waiting for DONE (or watchdog expiry)
   // RESPOND | response held until RSP_READY
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_GUARD,
      S_WAIT,
      S_RESPOND
   } state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] rr_ptr, tag, grant_idx, scan_idx;
   logic            grant_vld;
   logic            timeout_hit;
   logic [31:0]     sel_a, sel_b;

   // Scan downward so the lowest offset from rr_ptr+1 is the one left standing.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (bus.REQ_VALID[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == ID_W'(k)) begin
            sel_a = bus.REQ_A[32*k +: 32];
            sel_b = bus.REQ_B[32*k +: 32];
         end
      end
   end

   always_comb begin
      bus.REQ_READY = '0;
      if (RESET_N && state == S_IDLE && grant_vld) begin
         bus.REQ_READY[grant_idx] = 1'b1;
      end
   end

   assign bus.DIV_START = (state == S_ISSUE);
   assign BUSY          = (state != S_IDLE);

`ifdef FPDIV_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (state == S_WAIT) && !bus.DIV_DONE &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wait_cnt    <= '0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         if (state == S_GUARD) begin
            wait_cnt <= '0;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (timeout_hit) begin
            TIMEOUT_ERR <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (grant_vld) state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_GUARD;
         S_GUARD:   state_nxt = S_WAIT;
         S_WAIT:    if (bus.DIV_DONE || timeout_hit) state_nxt = S_RESPOND;
         S_RESPOND: if (bus.RSP_READY) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         rr_ptr            <= ID_W'(NUM_REQ - 1);
         tag               <= '0;
         bus.DIV_A         <= '0;
         bus.DIV_B         <= '0;
         bus.RSP_VALID     <= 1'b0;
         bus.RSP_ID        <= '0;
         bus.RSP_RESULT    <= '0;
         bus.RSP_EXCEPTION <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  bus.DIV_A <= sel_a;
                  bus.DIV_B <= sel_b;
                  tag       <= grant_idx;
                  rr_ptr    <= grant_idx;
               end
            end
            S_WAIT: begin
               if (bus.DIV_DONE) begin
                  bus.RSP_VALID     <= 1'b1;
                  bus.RSP_RESULT    <= bus.DIV_RESULT;
                  bus.RSP_EXCEPTION <= bus.DIV_EXCEPTION;
                  bus.RSP_ID        <= tag;
               end else if (timeout_hit) begin
                  bus.RSP_VALID     <= 1'b1;
                  bus.RSP_RESULT    <= 32'h7FC0_0000;
                  bus.RSP_EXCEPTION <= 2'b11;
                  bus.RSP_ID        <= tag;
               end
            end
            S_RESPOND: begin
               if (bus.RSP_READY) begin
                  bus.RSP_VALID <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter with a latency-programmable divider model and a
// cycle-level behavioural model of the arbitration/response contract.
module tb_fpdiv_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int TO  = 16;

   logic clk = 1'b0;
   logic RESET_N = 1'b0;
   logic busy;
`ifdef FPDIV_TIMEOUT_EN
   logic timeout_err;
`endif

   always #5 clk = ~clk;

   fpdiv_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

   fpdiv_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK   (clk),
      .RESET_N (RESET_N),
      .bus     (bus),
      .BUSY    (busy)
`ifdef FPDIV_TIMEOUT_EN
      ,
      .TIMEOUT_ERR (timeout_err)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stand-in for the divider datapath: {exception, quotient}.
   function automatic logic [33:0] div_fn(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (a == 32'h40C0_0000 && b == 32'h4000_0000) r = 32'h4040_0000;
      else r = a ^ {b[15:0], b[31:16]};
      return {a[1:0] ^ b[1:0], r};
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int i = 1; i <= N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   // Divider model: DONE stays high with the old result for dv_hold edges after the start
   // edge, then low, then high with the new result from edge dv_lat onward.
   int          dv_lat  = 5;
   int          dv_hold = 0;
   int          dv_t    = 0;
   bit          dv_run  = 0;
   logic        dv_done = 1'b0;
   logic [31:0] dv_res  = '0;
   logic [1:0]  dv_exc  = '0;
   logic [31:0] dv_new_res = '0;
   logic [1:0]  dv_new_exc = '0;

   assign bus.DIV_DONE      = dv_done;
   assign bus.DIV_RESULT    = dv_res;
   assign bus.DIV_EXCEPTION = dv_exc;

   always @(posedge clk) begin
      if (bus.DIV_START) begin
         dv_run <= 1'b1;
         dv_t   <= 0;
         {dv_new_exc, dv_new_res} <= div_fn(bus.DIV_A, bus.DIV_B);
         if (dv_hold == 0) dv_done <= 1'b0;
      end else if (dv_run) begin
         dv_t <= dv_t + 1;
         if (dv_t + 1 >= dv_lat) begin
            dv_done <= 1'b1;
            dv_res  <= dv_new_res;
            dv_exc  <= dv_new_exc;
            dv_run  <= 1'b0;
         end else if (dv_t + 1 >= dv_hold) begin
            dv_done <= 1'b0;
         end
      end
   end

   // Behavioural model: one job in flight from grant until the response handshake.
   bit              m_busy, m_pend, m_to_err;
   int              m_phase;
   logic [IDW-1:0]  m_ptr, m_tag;
   logic [31:0]     m_a, m_b, m_res;
   logic [1:0]      m_exc;
   int              start_cnt = 0;
   int              rsp_cycles = 0;
   time             start_time = 0;
   int              grant_log[$];

   always @(negedge clk) begin
      logic [N-1:0] exp_ready;
      int g;
      if (!RESET_N) begin
         m_busy = 0; m_pend = 0; m_phase = 0; m_to_err = 0;
         m_ptr = IDW'(N - 1); m_tag = '0; m_a = '0; m_b = '0; m_res = '0; m_exc = '0;
      end
      g = (RESET_N && !m_busy) ? rr_pick(bus.REQ_VALID, int'(m_ptr)) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", bus.REQ_READY, exp_ready);
      chk("div_start", bus.DIV_START, m_busy && m_phase == 1);
      chk("busy", busy, m_busy);
      chk("div_a", bus.DIV_A, m_a);
      chk("div_b", bus.DIV_B, m_b);
      chk("rsp_valid", bus.RSP_VALID, m_pend);
      if (m_pend || !RESET_N) begin
         chk("rsp_id", bus.RSP_ID, m_tag);
         chk("rsp_result", bus.RSP_RESULT, m_res);
         chk("rsp_exception", bus.RSP_EXCEPTION, m_exc);
      end
`ifdef FPDIV_TIMEOUT_EN
      chk("timeout_err", timeout_err, m_to_err);
`endif
      if (bus.DIV_START) begin
         start_cnt++;
         start_time = $time;
      end
      if (RESET_N && bus.RSP_VALID) rsp_cycles++;
      if (RESET_N && |bus.REQ_READY) grant_log.push_back($clog2(bus.REQ_READY));
      if (RESET_N) begin
         if (!m_busy) begin
            if (g >= 0) begin
               m_busy = 1; m_phase = 1;
               m_ptr = IDW'(g); m_tag = IDW'(g);
               m_a = bus.REQ_A[32*g +: 32];
               m_b = bus.REQ_B[32*g +: 32];
            end
         end else if (m_pend) begin
            if (bus.RSP_READY) begin
               m_busy = 0; m_pend = 0;
            end
         end else begin
            if (m_phase >= 3 && bus.DIV_DONE) begin
               m_pend = 1;
               {m_exc, m_res} = div_fn(m_a, m_b);
            end
`ifdef FPDIV_TIMEOUT_EN
            else if (m_phase >= 3 && m_phase - 3 == TO - 1) begin
               m_pend = 1; m_res = 32'h7FC0_0000; m_exc = 2'b11; m_to_err = 1;
            end
`endif
            m_phase++;
         end
      end
   end

   task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
      bit seen = 0;
      @(posedge clk); #1;
      bus.REQ_A[32*k +: 32] = a;
      bus.REQ_B[32*k +: 32] = b;
      bus.REQ_VALID[k] = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.REQ_READY[k]) seen = 1;
      end
      chk("grant_wait", seen, 1);
      @(posedge clk); #1;
      bus.REQ_VALID[k] = 1'b0;
   endtask

   task automatic wait_rsp(output time t);
      bit seen = 0;
      t = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (bus.RSP_VALID) begin
            seen = 1;
            t = $time;
         end
      end
      chk("rsp_wait", seen, 1);
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      RESET_N = 1'b0;
      repeat (2) @(posedge clk);
      #1 RESET_N = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      time t_rsp;
      int  n, r0;
      int  exp_order[5] = '{0, 1, 2, 3, 0};
      bus.REQ_VALID = '0;
      bus.REQ_A     = '0;
      bus.REQ_B     = '0;
      bus.RSP_READY = 1'b0;
      RESET_N       = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", bus.RSP_VALID, 0);
      chk("rst_div_a", bus.DIV_A, 0);
      chk("rst_div_start", bus.DIV_START, 0);
      @(posedge clk); #1 RESET_N = 1'b1;

      // single request, 6.0 / 2.0
      bus.RSP_READY = 1'b1;
      start_cnt = 0;
      issue(0, 32'h40C0_0000, 32'h4000_0000);
      wait_rsp(t_rsp);
      chk("t1_result", bus.RSP_RESULT, 32'h4040_0000);
      chk("t1_id", bus.RSP_ID, 0);
      chk("t1_exception", bus.RSP_EXCEPTION, 0);
      repeat (3) @(negedge clk);
      chk("t1_start_pulses", start_cnt, 1);

      // all requesters continuously valid
      apply_reset();
      grant_log.delete();
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         bus.REQ_A[32*k +: 32] = 32'h3F80_0000 | k;
         bus.REQ_B[32*k +: 32] = 32'h0001_0000 * (k + 1);
      end
      bus.REQ_VALID = '1;
      for (int i = 0; i < 400 && grant_log.size() < 5; i++) @(negedge clk);
      @(posedge clk); #1 bus.REQ_VALID = '0;
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      chk("t2_grant_count", grant_log.size() >= 5, 1);
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size()) chk($sformatf("t2_grant%0d", i), grant_log[i], exp_order[i]);
      end

      // response back-pressure with a competing request pending
      bus.RSP_READY = 1'b0;
      issue(2, 32'h1111_0000, 32'h0000_2222);
      bus.REQ_A[32 +: 32] = 32'h0F0F_0F0F;
      bus.REQ_B[32 +: 32] = 32'h0001_0002;
      bus.REQ_VALID[1] = 1'b1;
      wait_rsp(t_rsp);
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_result", bus.RSP_RESULT, 32'h3333_0000);
         chk("t3_hold_exception", bus.RSP_EXCEPTION, 2'b10);
         chk("t3_hold_id", bus.RSP_ID, 2);
         chk("t3_no_ready", bus.REQ_READY, 0);
         @(negedge clk);
      end
      @(posedge clk); #1 bus.RSP_READY = 1'b1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n++;
         if (bus.REQ_READY[1]) break;
      end
      chk("t3_regrant_delay", n, 2);
      @(posedge clk); #1 bus.REQ_VALID[1] = 1'b0;
      wait_rsp(t_rsp);
      chk("t3_req1_result", bus.RSP_RESULT, 32'h0F0D_0F0E);
      chk("t3_req1_id", bus.RSP_ID, 1);
      chk("t3_req1_exception", bus.RSP_EXCEPTION, 2'b01);

      // stale DONE carried through ISSUE/GUARD, re-raised after 4 low cycles
      dv_hold = 1;
      dv_lat  = 5;
      issue(2, 32'h1234_5678, 32'h0000_FFFF);
      wait_rsp(t_rsp);
      chk("t4_result", bus.RSP_RESULT, 32'hEDCB_5678);
      chk("t4_exception", bus.RSP_EXCEPTION, 2'b11);
      chk("t4_id", bus.RSP_ID, 2);
      chk("t4_latency", (t_rsp - start_time) / 10, 7);
      dv_hold = 0;

      // asynchronous reset while waiting on the divider
      dv_lat = 20;
      issue(1, 32'h2222_3333, 32'h0000_0004);
      repeat (4) @(posedge clk);
      #3 RESET_N = 1'b0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_rsp_valid", bus.RSP_VALID, 0);
      chk("t5_div_a", bus.DIV_A, 0);
      chk("t5_div_b", bus.DIV_B, 0);
      chk("t5_div_start", bus.DIV_START, 0);
      chk("t5_rsp_result", bus.RSP_RESULT, 0);
      repeat (3) @(posedge clk);
      #1 RESET_N = 1'b1;
      r0 = rsp_cycles;
      repeat (30) @(negedge clk);
      chk("t5_no_response", rsp_cycles, r0);
      dv_lat = 5;
      issue(1, 32'h2222_3333, 32'h0000_0004);
      wait_rsp(t_rsp);
      chk("t5_result", bus.RSP_RESULT, 32'h2226_3333);
      chk("t5_id", bus.RSP_ID, 1);
      chk("t5_exception", bus.RSP_EXCEPTION, 2'b11);

`ifdef FPDIV_TIMEOUT_EN
      // divider never finishes
      dv_lat = 100000;
      bus.RSP_READY = 1'b0;
      issue(3, 32'h4000_0000, 32'h0000_0000);
      wait_rsp(t_rsp);
      chk("t6_result", bus.RSP_RESULT, 32'h7FC0_0000);
      chk("t6_exception", bus.RSP_EXCEPTION, 2'b11);
      chk("t6_id", bus.RSP_ID, 3);
      chk("t6_latency", (t_rsp - start_time) / 10, 18);
      chk("t6_err_set", timeout_err, 1);
      @(posedge clk); #1 bus.RSP_READY = 1'b1;
      repeat (5) @(negedge clk);
      chk("t6_err_sticky", timeout_err, 1);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
